shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares one shift datapath (alu_shifter instance) between NUM_REQ requesters, e.g. the execute stage and the load/store byte-alignment logic.
- Each requester uses a valid/ready request channel.
- Arbitration is round-robin.
- One registered result stage drives a single tagged response channel.
- Sits beside the ALU in the execute datapath. Also keeps a saturating contention counter for performance debug.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ) (min 1), width of the requester tag.
- CNT_W, 16, width of the contention counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  in  NUM_REQ*32  operand a, requester i at bits [32i+31:32i].
- req_shamt  in  NUM_REQ*5  shift amount, requester i at [5i+4:5i].
- req_type  in  NUM_REQ*2  shift type per requester: 00 SLL, 01 SRL, 10 SRA, 11 illegal.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_result  out  32  shifted value.
- resp_id  out  ID_W  index of the requester that owns resp_result.
- resp_illegal  out  1  request used type 11; resp_result is 0.
- contention_cnt  out  CNT_W  saturating count of cycles with >1 req_valid asserted.

Behaviour:
- Reset (rst=1 at clk edge):
  - resp_valid=0, resp_result=0, resp_id=0, resp_illegal=0.
  - rr_ptr=0, contention_cnt=0.
  - req_ready is forced to 0 while rst=1.
- can_accept = !resp_valid || resp_ready (combinational).
- Grant:
  - Combinational round-robin search over req_valid, starting at rr_ptr and wrapping modulo NUM_REQ.
  - The first valid index wins.
  - req_ready[i] = grant[i] && can_accept && !rst.
- Accept (req_valid[i] && req_ready[i]) at edge N:
  - resp_result <= shift(req_a[i], req_shamt[i], req_type[i]).
  - resp_id <= i.
  - resp_illegal <= (req_type[i]==11).
  - resp_valid <= 1.
  - rr_ptr <= (i+1) mod NUM_REQ.
  - Result is visible in cycle N+1: one-cycle latency.
- Throughput: one accept per cycle while resp_ready=1. A new accept and a response drain in the same cycle overwrite the output register with no bubble.
- Drain without accept: if resp_valid && resp_ready and there is no accept, resp_valid <= 0. The other response fields hold their values.
- Stall: if resp_valid && !resp_ready, then req_ready=0 for all requesters. All resp_* outputs are held stable, and rr_ptr is held.
- Requester rule:
  - Once req_valid[i] is raised, it stays high with stable a/shamt/type until accepted.
  - The bench flags any violation; the RTL does not check it.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 accepts before it is granted.
- rr_ptr changes only on accept. Idle cycles do not move it.
- Shift semantics:
  - SLL/SRL are logical.
  - SRA replicates bit 31.
  - shamt 0 passes a unchanged.
  - shamt 31 is the maximum.
  - Type 11 gives result 0 with resp_illegal=1.
- contention_cnt:
  - Increments each cycle where popcount(req_valid) >= 2, regardless of stall.
  - Saturates at all-ones and never wraps.
  - Reset is the only clear.
- Reset mid-operation: any held response is discarded (resp_valid=0 the cycle after rst). Requests pending during rst are not accepted.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [1:0] shift_type_e {SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_ILL=2'b11}.
  - localparam XLEN=32.
  - localparam SHAMT_W=5.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, ptr, en.
  - Output: one-hot grant.
  - Purely combinational, reusable elsewhere.
- The shift datapath is a single existing alu_shifter instance, fed by a NUM_REQ:1 operand mux driven by the grant.

Test Plan:
- Single requester: req0 a=0x8000_00F0, shamt=4, type=SRA, resp_ready=1 -> cycle N+1: resp_valid=1, result=0xF800_000F, id=0, illegal=0; resp_valid=0 at N+2.
- Round-robin: req0 and req1 both valid continuously, each with a=0x1, shamt=1, type SLL, resp_ready=1 -> grants alternate 0,1,0,1; each result=0x2; contention_cnt increments every cycle.
- Backpressure: resp_ready=0 after the first accept of req1 (a=0xF0, shamt=4, SRL) -> result=0x0F held stable and req_ready=0 for 5 cycles; when resp_ready=1, the next request is accepted in that same cycle with no bubble.
- Boundaries:
  - shamt=0 on a=0xDEAD_BEEF, SLL -> 0xDEAD_BEEF.
  - shamt=31 on a=0x8000_0000: SRA -> 0xFFFF_FFFF; SRL -> 0x1.
  - type=11 -> result 0, illegal=1.
- Reset mid-operation: rst asserted while resp_valid=1 and resp_ready=0 -> next cycle resp_valid=0, rr_ptr=0, contention_cnt=0, req_ready=0 during rst.
- Saturation: CNT_W=4, hold 2 valids with resp_ready=0 for 20 cycles -> contention_cnt stops at 0xF.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and widths for the shared shift datapath and its arbiter.
package shift_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ILL = 2'b11
  } shift_type_e;

endpackage

// File: rtl/shift_arbiter_alu_shifter.sv
// Combinational 32-bit shifter: logical left/right, arithmetic right.
// The reserved type code yields zero and raises illegal_o.
module alu_shifter
  import shift_pkg::*;
(
  input  logic [XLEN-1:0]    a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  shift_type_e        type_i,
  output logic [XLEN-1:0]    result_o,
  output logic               illegal_o
);

  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    case (type_i)
      SHIFT_SLL: result_o = a_i << shamt_i;
      SHIFT_SRL: result_o = a_i >> shamt_i;
      SHIFT_SRA: result_o = $unsigned($signed(a_i) >>> shamt_i);
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant of the first request at or
// after ptr_i, wrapping to index 0. No grant when en_i is low.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o
);

  logic [N-1:0] mask_hi;
  logic [N-1:0] req_hi;
  logic [N-1:0] first_hi;
  logic [N-1:0] first_all;

  // Requests at or above the pointer take priority over the wrapped ones.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign mask_hi[gi] = (32'(gi) >= 32'(ptr_i));
  end

  assign req_hi    = req_i & mask_hi;
  assign first_hi  = req_hi & (~req_hi + N'(1));
  assign first_all = req_i & (~req_i + N'(1));

  always_comb begin
    grant_o = '0;
    if (en_i) begin
      grant_o = (|req_hi) ? first_hi : first_all;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one shifter among NUM_REQ valid/ready requesters,
// with a single registered tagged response and a saturating contention counter.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*XLEN-1:0]    req_a,
  input  logic [NUM_REQ*SHAMT_W-1:0] req_shamt,
  input  logic [NUM_REQ*2-1:0]       req_type,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [XLEN-1:0]            resp_result,
  output logic [ID_W-1:0]            resp_id,
  output logic                       resp_illegal,
  output logic [CNT_W-1:0]           contention_cnt
);

  localparam int CW = $clog2(NUM_REQ + 1);

  logic [NUM_REQ-1:0] grant;
  logic               can_accept;
  logic               accept;

  logic [XLEN-1:0]    op_a     [NUM_REQ];
  logic [SHAMT_W-1:0] op_shamt [NUM_REQ];
  logic [1:0]         op_type  [NUM_REQ];

  logic [XLEN-1:0]    sel_a;
  logic [SHAMT_W-1:0] sel_shamt;
  logic [1:0]         sel_type;
  logic [ID_W-1:0]    grant_idx;

  logic [XLEN-1:0]    shift_result;
  logic               shift_illegal;

  logic [CW-1:0]      nvalid;
  logic               contention;

  logic               valid_q,   valid_d;
  logic [XLEN-1:0]    result_q,  result_d;
  logic [ID_W-1:0]    id_q,      id_d;
  logic               illegal_q, illegal_d;
  logic [ID_W-1:0]    ptr_q,     ptr_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_a[gi]     = req_a[XLEN*gi +: XLEN];
    assign op_shamt[gi] = req_shamt[SHAMT_W*gi +: SHAMT_W];
    assign op_type[gi]  = req_type[2*gi +: 2];
  end

  assign can_accept = !valid_q || resp_ready;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (ID_W)
  ) u_rr_arbiter (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .en_i    (can_accept && !rst),
    .grant_o (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // Grant is one-hot, so an AND-OR mux selects the winner's operands.
  always_comb begin
    sel_a     = '0;
    sel_shamt = '0;
    sel_type  = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a     = sel_a | op_a[i];
        sel_shamt = sel_shamt | op_shamt[i];
        sel_type  = sel_type | op_type[i];
        grant_idx = ID_W'(i);
      end
    end
  end

  alu_shifter u_alu_shifter (
    .a_i       (sel_a),
    .shamt_i   (sel_shamt),
    .type_i    (shift_type_e'(sel_type)),
    .result_o  (shift_result),
    .illegal_o (shift_illegal)
  );

  always_comb begin
    nvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      nvalid = nvalid + CW'(req_valid[i]);
    end
  end

  assign contention = (nvalid >= CW'(2));

  always_comb begin
    valid_d   = valid_q;
    result_d  = result_q;
    id_d      = id_q;
    illegal_d = illegal_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    if (accept) begin
      valid_d   = 1'b1;
      result_d  = shift_result;
      id_d      = grant_idx;
      illegal_d = shift_illegal;
      ptr_d     = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end else if (resp_ready) begin
      valid_d = 1'b0;
    end
    if (contention && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      id_q      <= '0;
      illegal_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      result_q  <= result_d;
      id_q      <= id_d;
      illegal_q <= illegal_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign resp_valid     = valid_q;
  assign resp_result    = result_q;
  assign resp_id        = id_q;
  assign resp_illegal   = illegal_q;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: latency, round-robin order, backpressure,
// shift boundaries, mid-operation reset and counter saturation.
module tb_shift_arbiter;
  import shift_pkg::*;

  localparam int NR = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid;
  logic [NR-1:0]  req_ready;
  logic [NR*32-1:0] req_a;
  logic [NR*5-1:0]  req_shamt;
  logic [NR*2-1:0]  req_type;
  logic           resp_valid;
  logic           resp_ready;
  logic [31:0]    resp_result;
  logic [0:0]     resp_id;
  logic           resp_illegal;
  logic [15:0]    contention_cnt;

  logic [NR-1:0]  sat_req_ready;
  logic           sat_resp_valid;
  logic [31:0]    sat_resp_result;
  logic [0:0]     sat_resp_id;
  logic           sat_resp_illegal;
  logic [3:0]     sat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.NUM_REQ(NR), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_shamt      (req_shamt),
    .req_type       (req_type),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_result    (resp_result),
    .resp_id        (resp_id),
    .resp_illegal   (resp_illegal),
    .contention_cnt (contention_cnt)
  );

  shift_arbiter #(.NUM_REQ(NR), .CNT_W(4)) dut_sat (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (sat_req_ready),
    .req_a          (req_a),
    .req_shamt      (req_shamt),
    .req_type       (req_type),
    .resp_valid     (sat_resp_valid),
    .resp_ready     (resp_ready),
    .resp_result    (sat_resp_result),
    .resp_id        (sat_resp_id),
    .resp_illegal   (sat_resp_illegal),
    .contention_cnt (sat_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [4:0] sh, input logic [1:0] ty);
    req_a[32*i +: 32]   = a;
    req_shamt[5*i +: 5] = sh;
    req_type[2*i +: 2]  = ty;
  endtask

  // Requester-rule monitor: a pending request must stay valid and unchanged.
  logic [NR-1:0] pend;
  logic [38:0]   held [NR];
  always @(negedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (pend[i]) begin
          checks++;
          assert (req_valid[i] && ({req_a[32*i +: 32], req_shamt[5*i +: 5], req_type[2*i +: 2]} === held[i]))
          else begin
            errors++;
            $error("FAIL hold_req%0d: valid %b data %h held %h", i, req_valid[i],
                   {req_a[32*i +: 32], req_shamt[5*i +: 5], req_type[2*i +: 2]}, held[i]);
          end
        end
        pend[i] <= req_valid[i] && !req_ready[i];
        held[i] <= {req_a[32*i +: 32], req_shamt[5*i +: 5], req_type[2*i +: 2]};
      end
    end
  end

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_shamt  = '0;
    req_type   = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(resp_valid), 32'h0);
    check("rst_result", resp_result, 32'h0);
    check("rst_id", 32'(resp_id), 32'h0);
    check("rst_illegal", 32'(resp_illegal), 32'h0);
    check("rst_cnt", 32'(contention_cnt), 32'h0);
    check("rst_cnt_sat", 32'(sat_cnt), 32'h0);
    req_valid = 2'b11;
    #1 check("ready_in_rst", 32'(req_ready), 32'h0);
    tick();
    check("cnt_in_rst", 32'(contention_cnt), 32'h0);
    rst = 1'b0;
    req_valid = '0;
    tick();

    // Single requester, arithmetic right shift, one-cycle latency
    set_req(0, 32'h8000_00F0, 5'd4, SHIFT_SRA);
    req_valid  = 2'b01;
    resp_ready = 1'b1;
    #1 check("ready_single", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    check("single_valid", 32'(resp_valid), 32'h1);
    check("single_result", resp_result, 32'hF800_000F);
    check("single_id", 32'(resp_id), 32'h0);
    check("single_ill", 32'(resp_illegal), 32'h0);
    tick();
    check("drain_valid", 32'(resp_valid), 32'h0);
    check("drain_result", resp_result, 32'hF800_000F);

    // Round-robin; pointer is 1 after the previous grant to requester 0
    set_req(0, 32'h1, 5'd1, SHIFT_SLL);
    set_req(1, 32'h1, 5'd1, SHIFT_SLL);
    req_valid = 2'b11;
    for (int k = 1; k <= 4; k++) begin
      #1 check("rr_ready", 32'(req_ready), (k % 2 == 1) ? 32'h2 : 32'h1);
      tick();
      check("rr_result", resp_result, 32'h2);
      check("rr_id", 32'(resp_id), (k % 2 == 1) ? 32'h1 : 32'h0);
      check("rr_cnt", 32'(contention_cnt), 32'(k));
      if (k == 3) set_req(1, 32'h0000_00F0, 5'd4, SHIFT_SRL);
    end

    // Backpressure: hold the response for 5 cycles, then accept with no bubble
    req_valid = 2'b10;
    #1 check("bp_ready", 32'(req_ready), 32'h2);
    tick();
    check("bp_result", resp_result, 32'h0000_000F);
    resp_ready = 1'b0;
    set_req(0, 32'hDEAD_BEEF, 5'd0, SHIFT_SLL);
    req_valid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      #1 check("stall_ready", 32'(req_ready), 32'h0);
      tick();
      check("stall_valid", 32'(resp_valid), 32'h1);
      check("stall_result", resp_result, 32'h0000_000F);
      check("stall_id", 32'(resp_id), 32'h1);
    end
    check("stall_cnt", 32'(contention_cnt), 32'h4);
    resp_ready = 1'b1;
    #1 check("unstall_ready", 32'(req_ready), 32'h1);
    tick();
    check("shamt0_result", resp_result, 32'hDEAD_BEEF);
    check("shamt0_id", 32'(resp_id), 32'h0);

    // Shift boundaries
    set_req(1, 32'h8000_0000, 5'd31, SHIFT_SRA);
    req_valid = 2'b10;
    tick();
    check("sra31_result", resp_result, 32'hFFFF_FFFF);
    check("sra31_id", 32'(resp_id), 32'h1);
    set_req(0, 32'h8000_0000, 5'd31, SHIFT_SRL);
    req_valid = 2'b01;
    tick();
    check("srl31_result", resp_result, 32'h0000_0001);
    check("srl31_id", 32'(resp_id), 32'h0);
    set_req(1, 32'h0000_1234, 5'd3, SHIFT_ILL);
    req_valid = 2'b10;
    tick();
    check("ill_valid", 32'(resp_valid), 32'h1);
    check("ill_result", resp_result, 32'h0);
    check("ill_flag", 32'(resp_illegal), 32'h1);
    check("ill_id", 32'(resp_id), 32'h1);
    set_req(0, 32'h0000_0001, 5'd31, SHIFT_SLL);
    req_valid = 2'b01;
    tick();
    check("sll31_result", resp_result, 32'h8000_0000);
    check("sll31_ill", 32'(resp_illegal), 32'h0);

    // Reset while a response is stalled
    resp_ready = 1'b0;
    set_req(0, 32'h5, 5'd1, SHIFT_SLL);
    set_req(1, 32'h5, 5'd1, SHIFT_SLL);
    req_valid = 2'b11;
    #1 check("pre_rst_ready", 32'(req_ready), 32'h0);
    tick();
    tick();
    check("pre_rst_cnt", 32'(contention_cnt), 32'h6);
    check("pre_rst_valid", 32'(resp_valid), 32'h1);
    check("pre_rst_result", resp_result, 32'h8000_0000);
    rst = 1'b1;
    #1 check("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    check("post_rst_valid", 32'(resp_valid), 32'h0);
    check("post_rst_result", resp_result, 32'h0);
    check("post_rst_cnt", 32'(contention_cnt), 32'h0);
    check("post_rst_cnt_sat", 32'(sat_cnt), 32'h0);
    rst = 1'b0;
    resp_ready = 1'b1;
    #1 check("post_rst_ready", 32'(req_ready), 32'h1);
    tick();
    check("post_rst_res", resp_result, 32'h0000_000A);
    check("post_rst_id", 32'(resp_id), 32'h0);
    check("post_rst_cnt1", 32'(contention_cnt), 32'h1);

    // Saturation of the 4-bit counter under sustained contention and stall
    resp_ready = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("sat_cnt16", 32'(contention_cnt), 32'(k + 1));
      check("sat_cnt4", 32'(sat_cnt), (k >= 14) ? 32'hF : 32'(k + 1));
    end
    check("sat_ready", 32'(req_ready), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
